// File: rtl/spi_command_queue.sv
// Purpose: ingress stage between the spi receiver and game_executioner: capture handshake, parity filter, command FIFO, game tick.
// Latency: a word is evaluated 3 clk edges after spi_data_valid rises; a pushed word reaches the FIFO head on that same edge.
// Backpressure: cmd_valid/cmd_ready on the consumer side; a word that arrives with the FIFO full and no pop that cycle is dropped and counted.
//
// Ports:
//   clk, reset_n                  single clock, asynchronous active-low reset
//   spi_data, spi_data_valid      word from spi (valid is asynchronous, held until spi_clear)
//   spi_clear                     clear request back to spi, high from evaluation until valid is seen low
//   cmd_data, cmd_valid, cmd_ready  FIFO head, consumer handshake
//   tick_enable, game_tick        gated tick generator, one-cycle pulse every TICK_DIV enabled cycles
//   fifo_level                    current occupancy
//   accepted_count, dropped_count saturating telemetry
module spi_command_queue #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 4,
    parameter int PARITY_CHECK = 1,
    parameter int TICK_DIV     = 4096,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_WIDTH-1:0]    spi_data,
    input  logic                     spi_data_valid,
    output logic                     spi_clear,
    output logic [DATA_WIDTH-1:0]    cmd_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    input  logic                     tick_enable,
    output logic                     game_tick,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [COUNT_WIDTH-1:0]   accepted_count,
    output logic [COUNT_WIDTH-1:0]   dropped_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PTR_W-1:0]       PTR_ONE   = 1;
    localparam logic [LVL_W-1:0]       LVL_ONE   = 1;
    localparam logic [LVL_W-1:0]       LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = 1;
    localparam logic [TICK_W-1:0]      TICK_ONE  = 1;
    localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state;
    logic                    valid_meta;
    logic                    valid_sync;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        last_ptr;
    logic [LVL_W-1:0]        level;

    logic [TICK_W-1:0]       tick_cnt;

    logic                    parity_ok;
    logic                    evaluate;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // spi_data is only looked at while the synchronized valid is high, by which
    // time it has been stable for at least two cycles, so only valid is synchronized.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_meta <= 1'b0;
            valid_sync <= 1'b0;
        end else begin
            valid_meta <= spi_data_valid;
            valid_sync <= valid_meta;
        end
    end

    always_comb begin
        parity_ok = (PARITY_CHECK == 0) || (^spi_data == 1'b0);
        evaluate  = (state == IDLE) && valid_sync;
        pop       = cmd_valid && cmd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push      = evaluate && parity_ok && ((level < LVL_FULL) || pop);
        drop      = evaluate && !push;
    end

    // Head decode. When empty, the slot just behind rd_ptr holds the last word
    // popped (or the reset zero), and writes never target it while empty.
    always_comb begin
        last_ptr   = rd_ptr - PTR_ONE;
        cmd_valid  = (level != '0);
        fifo_level = level;
        cmd_data   = cmd_valid ? mem[rd_ptr] : mem[last_ptr];
    end

    // Capture handshake: one evaluation per valid assertion, clear held until
    // the spi block has visibly released valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            spi_clear <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_sync) begin
                        spi_clear <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!valid_sync) begin
                        spi_clear <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    spi_clear <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Circular buffer; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= spi_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accepted_count <= '0;
            dropped_count  <= '0;
        end else begin
            if (push && (accepted_count != '1)) begin
                accepted_count <= accepted_count + CNT_ONE;
            end
            if (drop && (dropped_count != '1)) begin
                dropped_count <= dropped_count + CNT_ONE;
            end
        end
    end

    // game_tick is registered on the wrap, so it is high the cycle after the
    // counter's last value; pausing clears it after any in-flight pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            game_tick <= 1'b0;
        end else if (tick_enable) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt  <= '0;
                game_tick <= 1'b1;
            end else begin
                tick_cnt  <= tick_cnt + TICK_ONE;
                game_tick <= 1'b0;
            end
        end else begin
            game_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_command_queue.sv
module tb_spi_command_queue;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] spi_data = 8'h00;
    logic       spi_data_valid = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       tick_enable = 1'b1;

    // u_a: defaults (parity check on, TICK_DIV 4096); u_b: parity off, TICK_DIV 1
    logic       spi_clear_a, cmd_valid_a, game_tick_a;
    logic [7:0] cmd_data_a, accepted_a, dropped_a;
    logic [2:0] level_a;
    logic       spi_clear_b, cmd_valid_b, game_tick_b;
    logic [7:0] cmd_data_b, accepted_b, dropped_b;
    logic [2:0] level_b;

    int checks = 0;
    int errors = 0;

    spi_command_queue u_a (
        .clk(clk), .reset_n(reset_n), .spi_data(spi_data), .spi_data_valid(spi_data_valid),
        .spi_clear(spi_clear_a), .cmd_data(cmd_data_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready),
        .tick_enable(tick_enable), .game_tick(game_tick_a), .fifo_level(level_a),
        .accepted_count(accepted_a), .dropped_count(dropped_a)
    );

    spi_command_queue #(.PARITY_CHECK(0), .TICK_DIV(1)) u_b (
        .clk(clk), .reset_n(reset_n), .spi_data(spi_data), .spi_data_valid(spi_data_valid),
        .spi_clear(spi_clear_b), .cmd_data(cmd_data_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready),
        .tick_enable(tick_enable), .game_tick(game_tick_b), .fifo_level(level_b),
        .accepted_count(accepted_b), .dropped_count(dropped_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] lvl;
        logic [7:0] acc_a;
        logic [7:0] drop_a;
        logic [7:0] acc_b;
        logic [7:0] drop_b;
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] exp_list [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Raise valid and advance to the negedge after the evaluating edge (edge 3).
    task automatic start_word(input logic [7:0] d);
        spi_data       = d;
        spi_data_valid = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Release valid and wait, bounded, for both spi_clear outputs to fall.
    task automatic finish_word();
        int n;
        n = 0;
        spi_data_valid = 1'b0;
        while ((spi_clear_a || spi_clear_b) && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (spi_clear_a || spi_clear_b)
            chk("clear_timeout", {30'd0, spi_clear_a, spi_clear_b}, 32'd0);
    endtask

    task automatic send(input logic [7:0] d, input int hold);
        start_word(d);
        repeat (hold - 3) @(negedge clk);
        finish_word();
    endtask

    // Pop four words from both DUTs (same contents), one per cycle.
    task automatic pop_four(input string tag);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_data_a%0d", tag, i), cmd_data_a, exp_list[i]);
            chk($sformatf("%s_data_b%0d", tag, i), cmd_data_b, exp_list[i]);
            chk($sformatf("%s_lvl_a%0d", tag, i), level_a, 4 - i);
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        chk({tag, "_empty_a"}, cmd_valid_a, 0);
        chk({tag, "_hold_a"}, cmd_data_a, exp_list[3]);
        chk({tag, "_lvl_b"}, level_b, 0);
    endtask

    initial begin
        int terr_a, terr_b, pulses_a;

        // Counts are cumulative: words 21 and 01 precede the table (01 is
        // dropped by u_a for odd parity, pushed by u_b).
        tbl[0] = '{8'h03, 3'd1, 8'd2, 8'd1, 8'd3, 8'd0};
        tbl[1] = '{8'h05, 3'd2, 8'd3, 8'd1, 8'd4, 8'd0};
        tbl[2] = '{8'h06, 3'd3, 8'd4, 8'd1, 8'd5, 8'd0};
        tbl[3] = '{8'h09, 3'd4, 8'd5, 8'd1, 8'd6, 8'd0};
        tbl[4] = '{8'h0A, 3'd4, 8'd5, 8'd2, 8'd6, 8'd1};

        // ---- reset state ----
        #1;
        chk("rst_clear", spi_clear_a, 0);
        chk("rst_valid", cmd_valid_a, 0);
        chk("rst_data", cmd_data_a, 0);
        chk("rst_tick", game_tick_a, 0);
        chk("rst_level", level_a, 0);
        chk("rst_counts", {accepted_a, dropped_a}, 0);
        repeat (2) @(negedge clk);
        chk("rst_tick_b", game_tick_b, 0);
        reset_n = 1'b1;

        // ---- tick generator: u_a every 4096, u_b every enabled cycle ----
        terr_a = 0; terr_b = 0; pulses_a = 0;
        for (int k = 1; k <= 12300; k++) begin
            @(negedge clk);
            if (game_tick_a !== ((k % 4096) == 0)) terr_a++;
            if (game_tick_b !== 1'b1) terr_b++;
            if (game_tick_a === 1'b1) pulses_a++;
        end
        chk("tick_a_period", terr_a, 0);
        chk("tick_a_pulses", pulses_a, 3);
        chk("tick_b_every", terr_b, 0);
        tick_enable = 1'b0;
        @(negedge clk);
        chk("tick_b_paused", game_tick_b, 0);
        repeat (3) @(negedge clk);
        chk("tick_b_stays", game_tick_b, 0);

        // ---- even word held 20 cycles, exact latency ----
        spi_data = 8'h21;
        spi_data_valid = 1'b1;
        @(negedge clk);
        chk("t2_e1_clear", spi_clear_a, 0);
        @(negedge clk);
        chk("t2_e2_valid", cmd_valid_a, 0);
        @(negedge clk);
        chk("t2_e3_clear", spi_clear_a, 1);
        chk("t2_e3_valid", cmd_valid_a, 1);
        chk("t2_e3_data", cmd_data_a, 8'h21);
        chk("t2_e3_level", level_a, 1);
        chk("t2_e3_acc", accepted_a, 1);
        repeat (17) @(negedge clk);
        spi_data_valid = 1'b0;
        @(negedge clk);
        chk("t2_fall1", spi_clear_a, 1);
        @(negedge clk);
        chk("t2_fall2", spi_clear_a, 1);
        @(negedge clk);
        chk("t2_fall3", spi_clear_a, 0);
        chk("t2_fall3_b", spi_clear_b, 0);
        chk("t2_once_acc", accepted_a, 1);
        chk("t2_once_lvl", level_a, 1);

        // ---- odd word: u_a drops, u_b pushes ----
        start_word(8'h01);
        chk("t3_clear", spi_clear_a, 1);
        chk("t3_drop_a", dropped_a, 1);
        chk("t3_lvl_a", level_a, 1);
        chk("t3_lvl_b", level_b, 2);
        finish_word();
        chk("t3_acc_b", accepted_b, 2);

        // ---- drain: u_a holds 21; u_b holds 21,01 ----
        cmd_ready = 1'b1;
        chk("drain_a0", cmd_data_a, 8'h21);
        chk("drain_b0", cmd_data_b, 8'h21);
        @(negedge clk);
        chk("drain_a_empty", cmd_valid_a, 0);
        chk("drain_a_hold", cmd_data_a, 8'h21);
        chk("drain_b1", cmd_data_b, 8'h01);
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("drain_b_empty", cmd_valid_b, 0);
        chk("drain_b_hold", cmd_data_b, 8'h01);
        @(negedge clk);
        chk("ready_empty_lvl", level_a, 0);

        // ---- table: fill to full, fifth word dropped ----
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].data, 4);
            chk($sformatf("vec%0d_lvl_a", i), level_a, tbl[i].lvl);
            chk($sformatf("vec%0d_lvl_b", i), level_b, tbl[i].lvl);
            chk($sformatf("vec%0d_acc_a", i), accepted_a, tbl[i].acc_a);
            chk($sformatf("vec%0d_drop_a", i), dropped_a, tbl[i].drop_a);
            chk($sformatf("vec%0d_acc_b", i), accepted_b, tbl[i].acc_b);
            chk($sformatf("vec%0d_drop_b", i), dropped_b, tbl[i].drop_b);
        end
        chk("full_head_a", cmd_data_a, 8'h03);

        // ---- push and pop on the same edge while full ----
        spi_data = 8'h11;
        spi_data_valid = 1'b1;
        repeat (2) @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("t5_lvl_a", level_a, 4);
        chk("t5_acc_a", accepted_a, 6);
        chk("t5_head_a", cmd_data_a, 8'h05);
        chk("t5_lvl_b", level_b, 4);
        chk("t5_acc_b", accepted_b, 7);
        finish_word();
        exp_list = '{8'h05, 8'h06, 8'h09, 8'h11};
        pop_four("t5pop");

        // ---- pointer wrap: four more words through the ring ----
        exp_list = '{8'h30, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 4; i++) send(exp_list[i], 4);
        chk("wrap_acc_a", accepted_a, 10);
        pop_four("wrap");

        // ---- reset mid-CLEAR with two entries queued ----
        send(8'h77, 4);
        send(8'h0F, 4);
        chk("t6_lvl2", level_a, 2);
        start_word(8'h3C);
        chk("t6_in_clear", spi_clear_a, 1);
        #2;
        reset_n = 1'b0;
        spi_data_valid = 1'b0;
        #1;
        chk("t6_async_clear", spi_clear_a, 0);
        chk("t6_async_valid", cmd_valid_a, 0);
        chk("t6_async_lvl", level_a, 0);
        chk("t6_async_data", cmd_data_a, 0);
        chk("t6_async_acc", accepted_a, 0);
        chk("t6_async_lvl_b", level_b, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_abandoned", level_a, 0);

        // ---- saturation: 300 odd words ----
        for (int i = 1; i <= 300; i++) begin
            send(8'h01, 3);
            if (i == 254) chk("sat_254", dropped_a, 254);
            if (i == 255) chk("sat_255", dropped_a, 255);
        end
        chk("sat_300_a", dropped_a, 255);
        chk("sat_acc_a", accepted_a, 0);
        chk("sat_300_b", dropped_b, 255);
        chk("sat_acc_b", accepted_b, 4);
        chk("sat_lvl_b", level_b, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_command_queue.md
Name: spi_command_queue

Overview:
Parametrised ingress stage between the spi receiver and game_executioner. It replaces the ad-hoc synchronizer pair (stall/invalidate) with four pieces:
- a 4-phase capture handshake against the spi block;
- optional parity filtering;
- a first-word-fall-through command FIFO with a valid/ready consumer port;
- a gated game-tick generator, plus saturating telemetry counters for decoder display.

Parameters:
DATA_WIDTH, 8, width of an spi command byte.
DEPTH, 4, FIFO entries; power of two, at least 2.
PARITY_CHECK, 1, when 1 only even-parity words are accepted; when 0 all words are accepted.
TICK_DIV, 4096, game_tick period in clk cycles; at least 1.
COUNT_WIDTH, 8, width of the telemetry counters.

Ports:
clk  input  1  single clock (LSOSC domain).
reset_n  input  1  asynchronous, active-low reset.
spi_data  input  DATA_WIDTH  received word; stable while spi_data_valid is high.
spi_data_valid  input  1  level from spi; asynchronous to clk; held until cleared.
spi_clear  output  1  clear request to spi (the spi block's clear input).
cmd_data  output  DATA_WIDTH  FIFO head.
cmd_valid  output  1  FIFO not empty.
cmd_ready  input  1  consumer accepts head.
tick_enable  input  1  tick counter runs when 1 (pause when 0).
game_tick  output  1  one-cycle pulse per TICK_DIV enabled cycles.
fifo_level  output  $clog2(DEPTH)+1  current occupancy.
accepted_count  output  COUNT_WIDTH  words pushed; saturating.
dropped_count  output  COUNT_WIDTH  words discarded for parity or full; saturating.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; FIFO empty; all counters 0.
  - spi_clear=0, cmd_valid=0, cmd_data=0, game_tick=0, fifo_level=0.
  - Reset mid-handshake abandons the word and clears the FIFO.
- Input sync: spi_data_valid passes through a 2-flop synchronizer giving vs. spi_data is sampled only when vs=1, so it needs no synchronizer.
- Capture FSM:
  - IDLE: if vs=1, at the next edge evaluate the word, push or drop it, set spi_clear=1, and go to CLEAR.
  - CLEAR: hold spi_clear=1. When vs=0, drop spi_clear at the next edge and go to IDLE.
  - Exactly one evaluation per valid assertion, regardless of how long valid is held.
- Latency: valid rises before edge 1. After edge 3, spi_clear=1 and, if pushed, cmd_valid=1 with fifo_level incremented.
- Accept rule:
  - Parity OK if PARITY_CHECK=0 or XOR-reduce(spi_data)=0.
  - Push if parity OK and (level<DEPTH, or a pop occurs in the same cycle). Otherwise drop.
  - Push increments accepted_count; drop increments dropped_count. Both counters saturate at all-ones.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - cmd_data = head entry, valid the same cycle cmd_valid=1. cmd_data holds its last value when empty.
  - Pop when cmd_valid and cmd_ready.
  - Simultaneous push and pop: level is unchanged; valid when full.
  - Push into an empty FIFO appears at the head one cycle later; there is no combinational bypass.
  - cmd_ready while empty has no effect.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 while tick_enable=1 and holds while 0.
  - game_tick=1 for the single cycle after the counter wraps from TICK_DIV-1 to 0.
  - With TICK_DIV=1, game_tick=1 every cycle following an enabled cycle.
  - Deasserting tick_enable suppresses further ticks; a tick already registered still completes.
- All outputs are registered except cmd_data, cmd_valid and fifo_level, which decode directly from flops.

Test Plan:
1. Reset with no traffic -> all outputs 0; game_tick first pulses exactly 4096 cycles after release with tick_enable=1; held 10 000 cycles -> pulses exactly every 4096 cycles.
2. spi_data=8'h21 (even parity), valid held 20 cycles, cmd_ready=0 -> one push; cmd_valid and spi_clear high after edge 3; cmd_data=21; accepted_count=1; spi_clear falls 3 cycles after valid drops.
3. spi_data=8'h01 (odd parity), PARITY_CHECK=1 -> no push, dropped_count=1, spi_clear handshake still completes. Rerun with PARITY_CHECK=0 -> pushed.
4. Push 5 words 8'h03,8'h05,8'h06,8'h09,8'h0A with DEPTH=4 and cmd_ready=0 -> fifo_level=4, fifth dropped, dropped_count=1. Then cmd_ready=1 -> pops 03,05,06,09 in order on consecutive cycles.
5. FIFO full with cmd_ready=1 on the same cycle a new word evaluates -> push and pop both happen, level stays 4, accepted_count increments; 8 words through DEPTH=4 verify pointer wrap ordering.
6. Assert reset_n low mid-CLEAR with 2 entries queued -> FIFO empty and spi_clear=0 immediately (async); 300 drops with COUNT_WIDTH=8 -> dropped_count saturates at 255.
